// File: rtl/cam_bram_v2.sv
`default_nettype none
// cam_bram_v2: sliced block-RAM CAM with masked AND/OR search, a 2-cycle search pipeline,
// serialised clear-old/set-new updates and a single-command flush.
module cam_bram_v2 #(
    parameter  int DATA_WIDTH  = 64,
    parameter  int ADDR_WIDTH  = 5,
    parameter  int SLICE_WIDTH = 9,
    localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH,
    localparam int ENTRIES     = 2 ** ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_valid,
    output logic                   write_ready,
    input  logic [ADDR_WIDTH-1:0]  write_addr,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_delete,
    input  logic                   flush,
    input  logic                   compare_valid,
    input  logic [DATA_WIDTH-1:0]  compare_data,
    input  logic [SLICE_COUNT-1:0] compare_mask,
    input  logic                   compare_mode,
    output logic                   match_valid,
    output logic [ENTRIES-1:0]     match_many,
    output logic [ENTRIES-1:0]     match_single,
    output logic [ADDR_WIDTH-1:0]  match_addr,
    output logic                   match,
    output logic [ENTRIES-1:0]     entry_valid,
    output logic                   init_done
);
    localparam int LAST_WIDTH = DATA_WIDTH - SLICE_WIDTH * (SLICE_COUNT - 1);

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_READ_OLD  = 3'd2,
        ST_CLEAR_OLD = 3'd3,
        ST_WAIT_NEW  = 3'd4,
        ST_SET_NEW   = 3'd5,
        ST_FLUSH     = 3'd6
    } state_t;

    state_t                  state;
    logic [SLICE_WIDTH-1:0]  sweep_cnt;
    logic [ADDR_WIDTH-1:0]   upd_addr;
    logic [DATA_WIDTH-1:0]   upd_data;
    logic                    upd_delete;
    logic [DATA_WIDTH-1:0]   old_key;
    logic [DATA_WIDTH-1:0]   shadow [ENTRIES];

    logic                    sweeping;
    logic                    clear_we;
    logic                    set_we;
    logic [DATA_WIDTH-1:0]   upd_key;

    assign write_ready = (state == ST_IDLE) && !rst;
    assign sweeping    = (state == ST_INIT) || (state == ST_FLUSH);
    // An entry that never held a key has no row bits to remove.
    assign clear_we    = (state == ST_CLEAR_OLD) && entry_valid[upd_addr];
    assign set_we      = (state == ST_SET_NEW);
    assign upd_key     = (state == ST_CLEAR_OLD) ? old_key : upd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            sweep_cnt   <= '1;
            init_done   <= 1'b0;
            entry_valid <= '0;
            upd_addr    <= '0;
            upd_data    <= '0;
            upd_delete  <= 1'b0;
        end else begin
            case (state)
                ST_INIT, ST_FLUSH: begin
                    sweep_cnt <= sweep_cnt - 1'b1;
                    if (sweep_cnt == '0) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush) begin
                        state       <= ST_FLUSH;
                        sweep_cnt   <= '1;
                        entry_valid <= '0;
                    end else if (write_valid) begin
                        state      <= ST_READ_OLD;
                        upd_addr   <= write_addr;
                        upd_data   <= write_data;
                        upd_delete <= write_delete;
                    end
                end
                ST_READ_OLD: state <= ST_CLEAR_OLD;
                ST_CLEAR_OLD: begin
                    if (upd_delete) begin
                        entry_valid[upd_addr] <= 1'b0;
                        state                 <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT_NEW;
                    end
                end
                ST_WAIT_NEW: state <= ST_SET_NEW;
                ST_SET_NEW: begin
                    entry_valid[upd_addr] <= 1'b1;
                    state                 <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_READ_OLD) begin
            old_key <= shadow[upd_addr];
        end
        if (!rst && (state == ST_CLEAR_OLD) && !upd_delete) begin
            shadow[upd_addr] <= upd_data;
        end
    end

    logic [SLICE_COUNT*ENTRIES-1:0] rows_flat;

    for (genvar k = 0; k < SLICE_COUNT; k++) begin : g_slice
        localparam int SW = (k == SLICE_COUNT - 1) ? LAST_WIDTH : SLICE_WIDTH;

        logic [ENTRIES-1:0] mem [2**SW];
        logic [ENTRIES-1:0] rd_q;
        logic [SW-1:0]      search_row;
        logic [SW-1:0]      upd_row;
        logic [SW-1:0]      sweep_row;

        assign search_row = compare_data[k*SLICE_WIDTH +: SW];
        assign upd_row    = upd_key[k*SLICE_WIDTH +: SW];
        assign sweep_row  = sweep_cnt[SW-1:0];
        assign rows_flat[k*ENTRIES +: ENTRIES] = rd_q;

        // Port A reads for search; port B sweeps rows or flips a single entry bit.
        always_ff @(posedge clk) begin
            rd_q <= mem[search_row];
            if (!rst) begin
                if (sweeping) begin
                    mem[sweep_row] <= '0;
                end else if (clear_we || set_we) begin
                    mem[upd_row][upd_addr] <= set_we;
                end
            end
        end
    end

    logic                   s1_valid;
    logic                   s1_busy;
    logic                   s1_mode;
    logic [SLICE_COUNT-1:0] s1_mask;
    logic [ENTRIES-1:0]     s1_ev;

    // entry_valid is sampled with the row read so both reflect the same update cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_busy  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_mask  <= '0;
            s1_ev    <= '0;
        end else begin
            s1_valid <= compare_valid;
            s1_busy  <= sweeping;
            s1_mode  <= compare_mode;
            s1_mask  <= compare_mask;
            s1_ev    <= entry_valid;
        end
    end

    logic [ENTRIES-1:0]    combined;
    logic [ENTRIES-1:0]    many_next;
    logic [ENTRIES-1:0]    single_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    always_comb begin
        combined = s1_mode ? '0 : '1;
        for (int k = 0; k < SLICE_COUNT; k++) begin
            if (s1_mask[k]) begin
                if (s1_mode) begin
                    combined = combined | rows_flat[k*ENTRIES +: ENTRIES];
                end else begin
                    combined = combined & rows_flat[k*ENTRIES +: ENTRIES];
                end
            end
        end
        many_next   = (s1_busy || (s1_mask == '0)) ? '0 : (combined & s1_ev);
        single_next = '0;
        addr_next   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (many_next[i]) begin
                single_next    = '0;
                single_next[i] = 1'b1;
                addr_next      = ADDR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_valid  <= 1'b0;
            match_many   <= '0;
            match_single <= '0;
            match_addr   <= '0;
            match        <= 1'b0;
        end else begin
            match_valid  <= s1_valid;
            match_many   <= s1_valid ? many_next : '0;
            match_single <= s1_valid ? single_next : '0;
            match_addr   <= s1_valid ? addr_next : '0;
            match        <= s1_valid && (many_next != '0);
        end
    end
endmodule
`default_nettype wire
